axil_master_bridge: RTL and testbench

- AXI4-Lite initiator that converts a simple single-request core-side port into AXI4-Lite read and write transactions.
- Drives the instruction/data memory wrappers' AW/W/B/AR/R channels from the core fetch or LSU side.
- One outstanding transaction at a time; the response is returned as a one-cycle pulse.

---
 rtl/axil_master_bridge.sv | 193 +++++++++++++++++++
 tb/tb_axil_master_bridge.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_master_bridge.sv
// axil_master_bridge: AXI4-Lite initiator for a single-request core port.
// Ports: clk, reset (sync, active-low); req_* in, rsp_* out; AW/W/B/AR/R
// AXI4-Lite master channels. Optional watchdog when AXIL_TIMEOUT_EN is
// defined (TIMEOUT_CYCLES cycles in any wait state aborts with rsp_err=1).
module axil_master_bridge #(
    parameter int         ADDR_W         = 12,
    parameter int         DATA_W         = 32,
    parameter logic [2:0] PROT           = 3'b000,
    parameter int         TIMEOUT_CYCLES = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_wstrb,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                awvalid,
    input  logic                awready,
    output logic [ADDR_W-1:0]   awaddr,
    output logic [2:0]          awprot,
    output logic                wvalid,
    input  logic                wready,
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] wstrb,
    input  logic                bvalid,
    output logic                bready,
    input  logic                bresp,
    output logic                arvalid,
    input  logic                arready,
    output logic [ADDR_W-1:0]   araddr,
    output logic [2:0]          arprot,
    input  logic                rvalid,
    output logic                rready,
    input  logic [DATA_W-1:0]   rdata,
    input  logic                rresp
);

    typedef enum logic [2:0] {
        IDLE, RD_ADDR, RD_DATA, WR_AW_W, WR_RESP, RSP
    } state_t;

    state_t state;
    logic   aw_done;
    logic   w_done;

    logic ar_hs, r_hs, aw_hs, w_hs, b_hs;
    logic aw_ok, w_ok;

    assign ar_hs = arvalid & arready;
    assign r_hs  = rvalid & rready;
    assign aw_hs = awvalid & awready;
    assign w_hs  = wvalid & wready;
    assign b_hs  = bvalid & bready;
    // A write channel counts as finished if it completed earlier or now.
    assign aw_ok = aw_done | aw_hs;
    assign w_ok  = w_done | w_hs;

    assign req_ready = (state == IDLE);
    assign awprot    = PROT;
    assign arprot    = PROT;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

`ifdef AXIL_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] tmo_cnt;
    logic          busy;
    logic          leave;
    logic          tmo;

    assign busy  = state inside {RD_ADDR, RD_DATA, WR_AW_W, WR_RESP};
    assign leave = (state == RD_ADDR && ar_hs)
                 | (state == RD_DATA && r_hs)
                 | (state == WR_AW_W && aw_ok && w_ok)
                 | (state == WR_RESP && b_hs);
    assign tmo   = busy && (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));

    // Cycles spent in the current wait state; restarts on every transition.
    always_ff @(posedge clk) begin
        if (!reset || !busy || leave || tmo)
            tmo_cnt <= '0;
        else
            tmo_cnt <= tmo_cnt + 1'b1;
    end
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            awvalid   <= 1'b0;
            wvalid    <= 1'b0;
            bready    <= 1'b0;
            arvalid   <= 1'b0;
            rready    <= 1'b0;
            awaddr    <= '0;
            araddr    <= '0;
            wdata     <= '0;
            wstrb     <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (req_we) begin
                            awaddr  <= req_addr;
                            wdata   <= req_wdata;
                            wstrb   <= req_wstrb;
                            awvalid <= 1'b1;
                            wvalid  <= 1'b1;
                            state   <= WR_AW_W;
                        end else begin
                            araddr  <= req_addr;
                            arvalid <= 1'b1;
                            state   <= RD_ADDR;
                        end
                    end
                end
                RD_ADDR: begin
                    if (ar_hs) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state   <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (r_hs) begin
                        rready    <= 1'b0;
                        rsp_rdata <= rdata;
                        rsp_err   <= ~rresp;
                        rsp_valid <= 1'b1;
                        state     <= RSP;
                    end
                end
                WR_AW_W: begin
                    if (aw_hs) begin
                        awvalid <= 1'b0;
                        aw_done <= 1'b1;
                    end
                    if (w_hs) begin
                        wvalid <= 1'b0;
                        w_done <= 1'b1;
                    end
                    if (aw_ok && w_ok) begin
                        bready <= 1'b1;
                        state  <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (b_hs) begin
                        bready    <= 1'b0;
                        rsp_rdata <= '0;
                        rsp_err   <= ~bresp;
                        rsp_valid <= 1'b1;
                        state     <= RSP;
                    end
                end
                RSP: begin
                    aw_done <= 1'b0;
                    w_done  <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
`ifdef AXIL_TIMEOUT_EN
            // Watchdog abort overrides whatever the wait state decided.
            if (tmo) begin
                awvalid   <= 1'b0;
                wvalid    <= 1'b0;
                bready    <= 1'b0;
                arvalid   <= 1'b0;
                rready    <= 1'b0;
                rsp_rdata <= '0;
                rsp_err   <= 1'b1;
                rsp_valid <= 1'b1;
                state     <= RSP;
            end
`endif
        end
    end

endmodule

// File: tb/tb_axil_master_bridge.sv
// tb_axil_master_bridge: directed scoreboard bench for axil_master_bridge.
// Reactive AXI slave with per-channel wait counts; monitor pops responses.
module tb_axil_master_bridge;

    localparam int AW  = 12;
    localparam int DW  = 32;
    localparam int SW  = DW / 8;
    localparam int TMO = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic [SW-1:0] req_wstrb = '0;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          awvalid;
    logic          awready = 1'b0;
    logic [AW-1:0] awaddr;
    logic [2:0]    awprot;
    logic          wvalid;
    logic          wready = 1'b0;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
    logic          bvalid = 1'b0;
    logic          bready;
    logic          bresp = 1'b1;
    logic          arvalid;
    logic          arready = 1'b0;
    logic [AW-1:0] araddr;
    logic [2:0]    arprot;
    logic          rvalid = 1'b0;
    logic          rready;
    logic [DW-1:0] rdata = '0;
    logic          rresp = 1'b1;

    always #5 clk = ~clk;

    axil_master_bridge #(
        .ADDR_W(AW), .DATA_W(DW), .PROT(3'b000), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
        .awprot(awprot),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .araddr(araddr),
        .arprot(arprot),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp)
    );

    typedef struct packed {
        logic [DW-1:0] rdata;
        logic          err;
    } exp_t;

    exp_t sbq[$];
    int   vecs = 0;
    int   errs = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    int   last_rsp_cyc = 0;
    int   r_hs_cyc = 0;
    int   ar_hs_n = 0;
    int   b_hs_n = 0;

    int            ar_wait = 0, aw_wait = 0, w_wait = 0;
    int            r_wait = 0, b_wait = 0;
    logic [DW-1:0] s_rdata = '0;
    logic          s_rresp = 1'b1;
    logic          s_bresp = 1'b1;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        if (arvalid && arready) ar_hs_n++;
        if (bvalid && bready) b_hs_n++;
        if (rvalid && rready) r_hs_cyc = cyc;
        cyc++;
    end

    // Slave: each ready/valid rises after <wait> cycles of the peer's signal.
    initial begin : slave
        int arc, awc, wc, rc, bc;
        arc = 0; awc = 0; wc = 0; rc = 0; bc = 0;
        forever begin
            @(negedge clk);
            if (arvalid) begin arready = (arc >= ar_wait); arc++; end
            else begin arready = 1'b0; arc = 0; end
            if (awvalid) begin awready = (awc >= aw_wait); awc++; end
            else begin awready = 1'b0; awc = 0; end
            if (wvalid) begin wready = (wc >= w_wait); wc++; end
            else begin wready = 1'b0; wc = 0; end
            if (rready) begin
                rvalid = (rc >= r_wait);
                rdata  = rvalid ? s_rdata : '0;
                rresp  = s_rresp;
                rc++;
            end else begin
                rvalid = 1'b0; rc = 0;
            end
            if (bready) begin
                bvalid = (bc >= b_wait);
                bresp  = s_bresp;
                bc++;
            end else begin
                bvalid = 1'b0; bc = 0;
            end
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rsp_valid) begin
                last_rsp_cyc = cyc;
                if (sbq.size() == 0) begin
                    chk("spurious_rsp", 64'(rsp_valid), 64'd0);
                end else begin
                    e = sbq.pop_front();
                    chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
                    chk("rsp_err", 64'(rsp_err), 64'(e.err));
                end
            end
        end
    end

    task automatic push(input logic [DW-1:0] d, input logic e);
        exp_t x;
        x.rdata = d;
        x.err   = e;
        sbq.push_back(x);
    endtask

    // Returns at the negedge of the cycle after acceptance (cycle 1).
    task automatic issue(input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [SW-1:0] s);
        int n;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        req_wstrb = s;
        acc_cyc   = cyc;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        if (sbq.size() != 0) begin
            chk("rsp_wait_expired", 64'(sbq.size()), 64'd0);
            sbq.delete();
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_req_ready"}, 64'(req_ready), 64'd1);
        chk({tag, "_valids"},
            64'({awvalid, wvalid, arvalid, rready, bready, rsp_valid}),
            64'd0);
        chk({tag, "_rsp_err"}, 64'(rsp_err), 64'd0);
        chk({tag, "_rsp_rdata"}, 64'(rsp_rdata), 64'd0);
        chk({tag, "_addrs"}, 64'({awaddr, araddr}), 64'd0);
        chk({tag, "_wdata"}, 64'({wdata, wstrb}), 64'd0);
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int a0, b0;
        repeat (3) @(negedge clk);
        chk_idle_outputs("reset");
        reset = 1'b1;

        // Zero-wait read
        s_rdata = 32'hDEADBEEF;
        push(32'hDEADBEEF, 1'b0);
        issue(1'b0, 12'h010, '0, '0);
        chk("rd_arvalid_c1", 64'(arvalid), 64'd1);
        chk("rd_araddr_c1", 64'(araddr), 64'h010);
        chk("arprot", 64'({arprot, awprot}), 64'd0);
        wait_done();
        chk("rd_latency", 64'(last_rsp_cyc - acc_cyc), 64'd3);
        @(negedge clk);
        chk("rd_req_ready_c4", 64'(req_ready), 64'd1);

        // Write, awready delayed 3 cycles, wready immediate
        aw_wait = 3;
        b0 = b_hs_n;
        push('0, 1'b0);
        issue(1'b1, 12'h020, 32'h12345678, 4'b0011);
        chk("wr_both_valid_c1", 64'({awvalid, wvalid}), 64'b11);
        chk("wr_awaddr", 64'(awaddr), 64'h020);
        chk("wr_wdata", 64'(wdata), 64'h12345678);
        chk("wr_wstrb", 64'(wstrb), 64'b0011);
        @(negedge clk);
        chk("wr_c2_aw1_w0", 64'({awvalid, wvalid}), 64'b10);
        @(negedge clk);
        chk("wr_c3_awvalid", 64'(awvalid), 64'd1);
        @(negedge clk);
        chk("wr_c4_awvalid", 64'(awvalid), 64'd1);
        @(negedge clk);
        chk("wr_c5_aw0_bready", 64'({awvalid, bready}), 64'b01);
        wait_done();
        chk("wr_b_handshakes", 64'(b_hs_n - b0), 64'd1);
        chk("wr_latency", 64'(last_rsp_cyc - acc_cyc), 64'd6);
        aw_wait = 0;

        // Error responses
        s_rresp = 1'b0;
        s_rdata = 32'hCAFEF00D;
        push(32'hCAFEF00D, 1'b1);
        issue(1'b0, 12'h0FC, '0, '0);
        wait_done();
        s_rresp = 1'b1;
        s_bresp = 1'b0;
        push('0, 1'b1);
        issue(1'b1, 12'h100, 32'hAAAA5555, 4'hF);
        wait_done();
        s_bresp = 1'b1;

        // Write with wready late, awready immediate
        w_wait = 2;
        push('0, 1'b0);
        issue(1'b1, 12'h104, 32'h0F0F0F0F, 4'b1000);
        @(negedge clk);
        chk("wr2_c2_aw0_w1", 64'({awvalid, wvalid}), 64'b01);
        wait_done();
        w_wait = 0;

        // Slow rvalid; stray req_valid pulses must be ignored
        r_wait  = 5;
        s_rdata = 32'h0BADCAFE;
        a0 = ar_hs_n;
        push(32'h0BADCAFE, 1'b0);
        issue(1'b0, 12'h044, '0, '0);
        for (int k = 2; k <= 6; k++) begin
            @(negedge clk);
            chk("rwait_rready", 64'(rready), 64'd1);
            chk("rwait_arvalid", 64'(arvalid), 64'd0);
            chk("rwait_req_ready", 64'(req_ready), 64'd0);
            req_valid = (k == 3 || k == 5);
            req_we    = (k == 5);
            req_addr  = 12'h3FF;
        end
        req_valid = 1'b0;
        wait_done();
        chk("rwait_ar_count", 64'(ar_hs_n - a0), 64'd1);
        chk("rwait_rsp_after_r", 64'(last_rsp_cyc - r_hs_cyc), 64'd1);
        @(negedge clk);
        chk("rwait_no_extra", 64'({awvalid, wvalid, arvalid}), 64'd0);
        r_wait = 0;

        // Reset while waiting in RD_DATA
        r_wait = 1000;
        issue(1'b0, 12'h080, '0, '0);
        @(negedge clk);
        chk("rst_rready_c2", 64'(rready), 64'd1);
        reset = 1'b0;
        @(negedge clk);
        chk_idle_outputs("midrst");
        reset  = 1'b1;
        r_wait = 0;
        repeat (6) @(negedge clk);

        // Recovery read after the abandoned transaction
        s_rdata = 32'h5A5A1234;
        push(32'h5A5A1234, 1'b0);
        issue(1'b0, 12'h0A8, '0, '0);
        wait_done();

`ifdef AXIL_TIMEOUT_EN
        ar_wait = 1000;
        push('0, 1'b1);
        issue(1'b0, 12'h0C0, '0, '0);
        repeat (7) @(negedge clk);
        chk("tmo_arvalid_c8", 64'(arvalid), 64'd1);
        @(negedge clk);
        chk("tmo_arvalid_c9", 64'(arvalid), 64'd0);
        wait_done();
        chk("tmo_latency", 64'(last_rsp_cyc - acc_cyc), 64'd9);
        ar_wait = 0;
`endif

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
